// File: rtl/window_flush_ctrl.sv
// window_flush_ctrl: passes video frames to window_buf and appends WIN_SIZE/2 pad lines after each frame.
// Optional macro WINDOW_FLUSH_LEAD_EN adds a LEAD state that also prepends pad lines before each frame.
module window_flush_ctrl #(
  parameter int TDATA_WIDTH   = 32,
  parameter int PX_WIDTH      = 30,
  parameter int WIN_SIZE      = 5,
  parameter int MAX_LINE_SIZE = 1920
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [TDATA_WIDTH-1:0] video_i_tdata,
  input  logic                   video_i_tvalid,
  output logic                   video_i_tready,
  input  logic                   video_i_tlast,
  input  logic                   video_i_tuser,
  output logic [TDATA_WIDTH-1:0] video_o_tdata,
  output logic                   video_o_tvalid,
  input  logic                   video_o_tready,
  output logic                   video_o_tlast,
  output logic                   video_o_tuser,
  input  logic [15:0]            frame_height_i,
  input  logic [PX_WIDTH-1:0]    pad_px_i,
  output logic                   busy_o
);
  localparam int PAD_LINES = WIN_SIZE / 2;
  localparam int PX_CNT_W  = $clog2(MAX_LINE_SIZE + 1);
  localparam int PL_W      = $clog2(PAD_LINES + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
`ifdef WINDOW_FLUSH_LEAD_EN
    S_LEAD = 2'd3,
`endif
    S_TAIL = 2'd2
  } state_t;

  state_t              r_state, w_next, w_sof_state;
  logic [PX_CNT_W-1:0] r_px_cnt, r_line_len;
  logic [15:0]         r_line_cnt, r_frame_h, w_fh;
  logic [PX_WIDTH-1:0] r_pad_px;
  logic [PL_W-1:0]     r_left;
  logic                r_busy;
  logic                w_sof, w_in_lead, w_in_pad, w_pad_valid, w_pad_fire, w_pad_last;
  logic                w_pad_done, w_pad_exit, w_early, w_pass_fire, w_frame_end, w_strip;

`ifdef WINDOW_FLUSH_LEAD_EN
  logic r_lead_sof, r_strip;
  assign w_in_lead   = (r_state == S_LEAD);
  assign w_strip     = r_strip;
  assign w_sof_state = ((r_line_len != PX_CNT_W'(0)) && (PAD_LINES != 0)) ? S_LEAD : S_PASS;
`else
  assign w_in_lead   = 1'b0;
  assign w_strip     = 1'b0;
  assign w_sof_state = S_PASS;
`endif

  assign w_sof       = video_i_tvalid && video_i_tuser;
  assign w_in_pad    = (r_state == S_TAIL) || w_in_lead;
  // r_left counts pad lines still owed, including a partial line being closed
  assign w_pad_valid = w_in_pad && (r_line_len != PX_CNT_W'(0)) && (r_left != PL_W'(0));
  assign w_pad_fire  = w_pad_valid && video_o_tready;
  assign w_pad_last  = (r_px_cnt >= (r_line_len - PX_CNT_W'(1)));
  assign w_pad_done  = w_pad_fire && w_pad_last && (r_left == PL_W'(1));
  assign w_pad_exit  = !w_pad_valid || w_pad_done;
  assign w_early     = (r_state == S_PASS) && w_sof && (r_line_cnt != 16'd0);
  assign w_pass_fire = (r_state == S_PASS) && !w_early && video_i_tvalid && video_o_tready;
  assign w_fh        = video_i_tuser ? frame_height_i : r_frame_h;
  assign w_frame_end = w_pass_fire && video_i_tlast && (w_fh != 16'd0) &&
                       ((r_line_cnt + 16'd1) == w_fh);
  assign busy_o      = r_busy;

  // State register and registered busy flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_in_pad;
    end
  end

  // Next-state and stream output decode
  always_comb begin
    w_next         = r_state;
    video_i_tready = 1'b0;
    video_o_tvalid = 1'b0;
    video_o_tdata  = video_i_tdata;
    video_o_tlast  = 1'b0;
    video_o_tuser  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sof) begin
          w_next = w_sof_state;
        end else begin
          video_i_tready = 1'b1;
        end
      end
      S_PASS: begin
        if (w_early) begin
          w_next = S_TAIL;
        end else begin
          video_i_tready = video_o_tready;
          video_o_tvalid = video_i_tvalid;
          video_o_tlast  = video_i_tlast;
          video_o_tuser  = video_i_tuser && !w_strip;
          if (w_frame_end) begin
            w_next = (PAD_LINES == 0) ? S_IDLE : S_TAIL;
          end else begin
            w_next = S_PASS;
          end
        end
      end
      S_TAIL: begin
        video_o_tvalid = w_pad_valid;
        video_o_tdata  = TDATA_WIDTH'(r_pad_px);
        video_o_tlast  = w_pad_valid && w_pad_last;
        if (w_pad_exit) begin
          w_next = w_sof ? w_sof_state : S_IDLE;
        end else begin
          w_next = S_TAIL;
        end
      end
`ifdef WINDOW_FLUSH_LEAD_EN
      S_LEAD: begin
        video_o_tvalid = w_pad_valid;
        video_o_tdata  = TDATA_WIDTH'(r_pad_px);
        video_o_tlast  = w_pad_valid && w_pad_last;
        video_o_tuser  = w_pad_valid && r_lead_sof;
        if (w_pad_exit) begin
          w_next = S_PASS;
        end else begin
          w_next = S_LEAD;
        end
      end
`endif
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Pixel/line counters, learned line length and pad sequencing
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_px_cnt   <= PX_CNT_W'(0);
      r_line_len <= PX_CNT_W'(0);
      r_line_cnt <= 16'd0;
      r_frame_h  <= 16'd0;
      r_pad_px   <= PX_WIDTH'(0);
      r_left     <= PL_W'(0);
`ifdef WINDOW_FLUSH_LEAD_EN
      r_lead_sof <= 1'b0;
      r_strip    <= 1'b0;
`endif
    end else begin
      if ((r_state != S_PASS) && (w_next == S_PASS)) begin
        r_px_cnt   <= PX_CNT_W'(0);
        r_line_cnt <= 16'd0;
      end else if (w_pass_fire) begin
        if (video_i_tuser) begin
          r_frame_h <= frame_height_i;
        end
        if (video_i_tlast) begin
          r_px_cnt   <= PX_CNT_W'(0);
          r_line_cnt <= r_line_cnt + 16'd1;
          if (r_line_cnt == 16'd0) begin
            r_line_len <= r_px_cnt + PX_CNT_W'(1);
          end
        end else begin
          r_px_cnt <= r_px_cnt + PX_CNT_W'(1);
        end
      end else if (w_pad_fire) begin
        if (w_pad_last) begin
          r_px_cnt <= PX_CNT_W'(0);
          r_left   <= r_left - PL_W'(1);
        end else begin
          r_px_cnt <= r_px_cnt + PX_CNT_W'(1);
        end
      end
      // An early new frame mid-line owes one extra (closing) line
      if ((r_state == S_PASS) && (w_next == S_TAIL)) begin
        r_left   <= PL_W'(PAD_LINES) + PL_W'(w_early && (r_px_cnt != PX_CNT_W'(0)));
        r_pad_px <= pad_px_i;
      end
`ifdef WINDOW_FLUSH_LEAD_EN
      if ((r_state != S_LEAD) && (w_next == S_LEAD)) begin
        r_left     <= PL_W'(PAD_LINES);
        r_pad_px   <= pad_px_i;
        r_lead_sof <= 1'b1;
        r_strip    <= 1'b1;
      end else begin
        if (w_pad_fire) begin
          r_lead_sof <= 1'b0;
        end
        if (w_pass_fire) begin
          r_strip <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_window_flush_ctrl.sv
// Bench for window_flush_ctrl (default build): table of frame scenarios with random backpressure,
// checked word-by-word against a frame-level model, plus reset / junk / busy sequences.
module tb_window_flush_ctrl;
  localparam int TDW = 32, PXW = 30, WIN = 5, PAD_LINES = WIN / 2, TMO = 400;

  typedef struct packed { logic [31:0] d; logic l; logic u; } word_t;
  typedef struct { int w; int h; int fh; int cut; logic [29:0] pad; int rdy; int exp_words; } vec_t;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [TDW-1:0]  video_i_tdata, video_o_tdata;
  logic            video_i_tvalid, video_i_tready, video_i_tlast, video_i_tuser;
  logic            video_o_tvalid, video_o_tready, video_o_tlast, video_o_tuser;
  logic [15:0]     frame_height_i;
  logic [PXW-1:0]  pad_px_i;
  logic            busy_o;

  int    n_vec = 0, n_err = 0;
  word_t exp_q[$];
  vec_t  tbl[7];

  window_flush_ctrl #(.TDATA_WIDTH(TDW), .PX_WIDTH(PXW), .WIN_SIZE(WIN), .MAX_LINE_SIZE(1920)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .video_i_tdata(video_i_tdata), .video_i_tvalid(video_i_tvalid), .video_i_tready(video_i_tready),
    .video_i_tlast(video_i_tlast), .video_i_tuser(video_i_tuser),
    .video_o_tdata(video_o_tdata), .video_o_tvalid(video_o_tvalid), .video_o_tready(video_o_tready),
    .video_o_tlast(video_o_tlast), .video_o_tuser(video_o_tuser),
    .frame_height_i(frame_height_i), .pad_px_i(pad_px_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic make_frame(input int w, input int h, output word_t f[$]);
    f.delete();
    for (int i = 0; i < w * h; i++)
      f.push_back('{d: $urandom, l: ((i % w) == (w - 1)), u: (i == 0)});
  endtask

  // Reference: frame words as sent, then close a partial line, then PAD_LINES full pad lines
  task automatic model_frame(input word_t f[$], input int sent, input int w, input logic [29:0] pad);
    int rem;
    for (int i = 0; i < sent; i++) exp_q.push_back(f[i]);
    rem = (w - (sent % w)) % w;
    for (int i = 0; i < rem; i++) exp_q.push_back('{d: {2'b00, pad}, l: (i == rem - 1), u: 1'b0});
    for (int i = 0; i < PAD_LINES * w; i++)
      exp_q.push_back('{d: {2'b00, pad}, l: ((i % w) == (w - 1)), u: 1'b0});
  endtask

  task automatic send_word(input word_t wd, input logic [15:0] fh);
    int n = 0;
    @(negedge clk);
    video_i_tdata = wd.d; video_i_tlast = wd.l; video_i_tuser = wd.u;
    video_i_tvalid = 1'b1; frame_height_i = fh;
    #1;
    while (!video_i_tready && n < TMO) begin
      @(negedge clk); #1; n++;
    end
    if (!video_i_tready) begin
      chk("send_timeout_tready", video_i_tready, 1'b1);
      video_i_tvalid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  // frame_height_i carries junk after the tuser word to show it is only sampled at frame start
  task automatic drive_frame(input word_t f[$], input int n, input int fh, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(3) == 0)) begin
        @(negedge clk); video_i_tvalid = 1'b0;
      end
      send_word(f[i], (i == 0) ? 16'(fh) : 16'($urandom_range(50, 1)));
    end
  endtask

  task automatic monitor(input int pct, input int exp_words);
    int got = 0, cyc = 0;
    bit st = 1'b0;
    word_t prev, e;
    while (exp_q.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      video_o_tready = ($urandom_range(99) < pct);
      #1; cyc++;
      if (st) chk("stall_hold", {video_o_tvalid, video_o_tdata, video_o_tlast, video_o_tuser}, {1'b1, prev});
      st   = video_o_tvalid && !video_o_tready;
      prev = '{d: video_o_tdata, l: video_o_tlast, u: video_o_tuser};
      if (video_o_tvalid && video_o_tready) begin
        e = exp_q.pop_front();
        chk($sformatf("word%0d", got), {video_o_tdata, video_o_tlast, video_o_tuser}, e);
        got++;
      end
    end
    chk("words_outstanding", 64'(exp_q.size()), 64'd0);
    chk("word_count", 64'(got), 64'(exp_words));
    video_o_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("idle_after_frame", video_o_tvalid, 1'b0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    word_t fa[$], fb[$];
    int sent;
    make_frame(v.w, v.h, fa);
    make_frame(v.w, v.h, fb);
    sent = (v.cut < 0) ? v.w * v.h : v.cut;
    exp_q.delete();
    model_frame(fa, sent, v.w, v.pad);
    model_frame(fb, v.w * v.h, v.w, v.pad);
    pad_px_i = v.pad;
    fork
      begin
        drive_frame(fa, sent, v.fh, v.rdy < 100);
        drive_frame(fb, v.w * v.h, v.h, v.rdy < 100);
        @(negedge clk); video_i_tvalid = 1'b0;
      end
      monitor(v.rdy, v.exp_words);
    join
  endtask

  initial begin
    word_t f[$];
    rst_i = 1'b1; video_i_tdata = 32'd0; video_i_tvalid = 1'b0; video_i_tlast = 1'b0;
    video_i_tuser = 1'b0; video_o_tready = 1'b1; frame_height_i = 16'd0; pad_px_i = 30'd0;
    //          w  h  fh cut  pad            rdy exp
    tbl[0] = '{4, 3, 3, -1, 30'h3FF,      100, 40};
    tbl[1] = '{4, 3, 3, -1, 30'h3FF,       50, 40};
    tbl[2] = '{4, 3, 3,  9, 30'h2AAAAAAA,  60, 40};
    tbl[3] = '{6, 2, 2, -1, 30'h3FFFFFFF,  70, 48};
    tbl[4] = '{3, 4, 0, -1, 30'h0,         80, 36};
    tbl[5] = '{5, 3, 3, 12, 30'h1234567,   60, 50};
    tbl[6] = '{1, 2, 2, -1, 30'h3F,       100, 8};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_tvalid", video_o_tvalid, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    @(negedge clk); rst_i = 1'b0;

    // junk before the first tuser is swallowed
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      video_i_tvalid = 1'b1; video_i_tdata = $urandom; video_i_tuser = 1'b0; video_i_tlast = (i == 3);
      #1;
      chk("junk_tvalid_o", video_o_tvalid, 1'b0);
      chk("junk_tready", video_i_tready, 1'b1);
    end
    @(negedge clk); video_i_tvalid = 1'b0;

    // reach TAIL, check busy lag, then reset mid-injection
    pad_px_i = 30'h155;
    make_frame(4, 3, f);
    drive_frame(f, 12, 3, 1'b0);
    @(negedge clk); video_i_tvalid = 1'b0; #1;
    chk("tail_busy_lag", busy_o, 1'b0);
    chk("tail_tvalid", video_o_tvalid, 1'b1);
    chk("tail_tdata", video_o_tdata, {2'b00, 30'h155});
    chk("tail_tuser", video_o_tuser, 1'b0);
    @(negedge clk); #1;
    chk("tail_busy", busy_o, 1'b1);
    rst_i = 1'b1; #1;
    chk("rst_async_tvalid", video_o_tvalid, 1'b0);
    chk("rst_async_busy", busy_o, 1'b0);
    @(negedge clk); rst_i = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i]);
      repeat (3) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
